display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit, common-anode,
//   7-segment display. Each digit is driven for REFRESH_CYCLES clocks.
//   Between digits all anodes are switched off for GUARD_CYCLES clocks so
//   that segment data never ghosts onto the neighbouring digit.
//
//   The displayed value is captured once per frame, when digit 0 starts,
//   so a frame never mixes two different values. All outputs are registered.
//
// Ports
//   clk        : system clock, all state updates on its rising edge
//   rst        : asynchronous, active-high reset
//   en         : scan enable; 0 blanks the display and parks the scan at digit 0
//   lz_blank   : 1 suppresses leading-zero digits (digit 0 is always shown)
//   din        : 32-bit value; digit i shows din[4i+3:4i]
//   an         : anode selects, active-low, at most one bit low
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   frame_done : one-cycle pulse after the digit-7 drive period ends
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
   parameter int REFRESH_CYCLES = 100000,
   parameter int GUARD_CYCLES   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        lz_blank,
   input  logic [31:0] din,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);

   // The timer only ever has to reach max(GUARD, REFRESH) - 1.
   localparam int MAX_CYC = (REFRESH_CYCLES > GUARD_CYCLES) ? REFRESH_CYCLES : GUARD_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TW-1:0] G_LAST = TW'(GUARD_CYCLES - 1);
   localparam logic [TW-1:0] R_LAST = TW'(REFRESH_CYCLES - 1);

   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [31:0]   frame_reg, frame_nxt;
   logic [7:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          frame_done_nxt;

   logic [31:0]   src;
   logic [3:0]    nib;
   logic          lead_zero;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Segment data for the digit about to be driven. On the digit-0 start
   // edge frame_reg is being loaded from din on that same edge, so decode
   // from din directly; the path still ends in the seg register.
   always_comb begin
      src       = (idx == 3'd0) ? din : frame_reg;
      nib       = src[{idx, 2'b00} +: 4];
      lead_zero = (idx != 3'd0) && ((src >> {idx, 2'b00}) == 32'd0);
   end

   always_comb begin
      state_nxt      = state;
      timer_nxt      = timer + TW'(1);
      idx_nxt        = idx;
      frame_nxt      = frame_reg;
      an_nxt         = an;
      seg_nxt        = seg;
      frame_done_nxt = 1'b0;

      if (!en) begin
         state_nxt = GUARD;
         timer_nxt = '0;
         idx_nxt   = 3'd0;
         an_nxt    = AN_OFF;
         seg_nxt   = SEG_OFF;
      end else begin
         case (state)
            GUARD: begin
               an_nxt  = AN_OFF;
               seg_nxt = SEG_OFF;
               if (timer == G_LAST) begin
                  state_nxt = DRIVE;
                  timer_nxt = '0;
                  if (idx == 3'd0) frame_nxt = din;
                  an_nxt  = ~(8'd1 << idx);
                  // lz_blank is looked at only here, so a change lands on
                  // the next digit rather than part-way through one.
                  seg_nxt = (lz_blank && lead_zero) ? SEG_OFF : decode(nib);
               end
            end
            DRIVE: begin
               if (timer == R_LAST) begin
                  state_nxt      = GUARD;
                  timer_nxt      = '0;
                  idx_nxt        = idx + 3'd1;
                  an_nxt         = AN_OFF;
                  seg_nxt        = SEG_OFF;
                  frame_done_nxt = (idx == 3'd7);
               end
            end
            default: begin
               state_nxt = GUARD;
               timer_nxt = '0;
               an_nxt    = AN_OFF;
               seg_nxt   = SEG_OFF;
            end
         endcase
      end
   end

   // Outputs share the asynchronous reset so the display blanks the moment
   // rst rises, even in the middle of a drive period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= GUARD;
         timer      <= '0;
         idx        <= 3'd0;
         frame_reg  <= 32'd0;
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         idx        <= idx_nxt;
         frame_reg  <= frame_nxt;
         an         <= an_nxt;
         seg        <= seg_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Bench for display_scan_ctrl with REFRESH_CYCLES=4, GUARD_CYCLES=2.
//   The reference model counts cycles since the scan started and derives
//   the expected digit, anodes, segments and frame_done from the slot and
//   frame arithmetic. It captures din at each digit-0 start and lz_blank at
//   each digit start.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

   localparam int R     = 4;
   localparam int G     = 2;
   localparam int SLOT  = G + R;
   localparam int FRAME = 8 * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        lz_blank;
   logic [31:0] din;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        frame_done;

   display_scan_ctrl #(.REFRESH_CYCLES(R), .GUARD_CYCLES(G)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .lz_blank   (lz_blank),
      .din        (din),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- model state ----------------
   int          checks = 0;
   int          errors = 0;
   int          c      = 0;      // cycles since scan start (0 = parked)
   int          t      = 0;      // absolute cycle counter
   logic [31:0] m_frame = 32'd0;
   logic        m_lz    = 1'b0;
   logic [31:0] exp_q[$];        // expected frame_done cycle stamps

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Advance one clock: the model follows the edge, then sampling happens
   // on the following falling edge.
   task automatic step();
      @(posedge clk);
      t++;
      if (rst) begin
         c = 0; m_frame = 32'd0; m_lz = 1'b0;
      end else if (!en) begin
         c = 0;
      end else begin
         c++;
         if (c % FRAME == G) m_frame = din;
         if (c % SLOT == G)  m_lz    = lz_blank;
      end
      @(negedge clk);
   endtask

   function automatic void model(output logic [7:0] ea, output logic [6:0] es, output logic ef);
      int          pos, k, off;
      logic [31:0] rest;
      pos = c % FRAME;
      k   = pos / SLOT;
      off = pos % SLOT;
      ef  = (c > 0) && (pos == 0);
      ea  = 8'hFF;
      es  = 7'h7F;
      if (off >= G) begin
         ea   = ~(8'h01 << k);
         rest = m_frame >> (4 * k);
         es   = (m_lz && k > 0 && rest == 32'd0) ? 7'h7F : seg_tbl[rest[3:0]];
      end
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; en = 1'b0; lz_blank = 1'b0; din = 32'd0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks += 3;
         if (an !== 8'hFF)        begin errors++; $display("FAIL reset_an got %h exp ff", an); end
         if (seg !== 7'h7F)       begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
         if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done); end
         step();
      end
   endtask

   task automatic test_basic_frame();
      logic [7:0] ea; logic [6:0] es; logic ef;
      rst = 1'b0; en = 1'b1; lz_blank = 1'b0; din = 32'h76543210;
      for (int i = 0; i < 50; i++) begin
         model(ea, es, ef);
         checks += 3;
         if (an !== ea)         begin errors++; $display("FAIL basic_an c=%0d got %h exp %h", c, an, ea); end
         if (seg !== es)        begin errors++; $display("FAIL basic_seg c=%0d got %h exp %h", c, seg, es); end
         if (frame_done !== ef) begin errors++; $display("FAIL basic_fd c=%0d got %b exp %b", c, frame_done, ef); end
         if (c == 2) begin
            checks++;
            if (an !== 8'hFE || seg !== 7'h40) begin errors++; $display("FAIL basic_digit0 got %h/%h exp fe/40", an, seg); end
         end
         if (c == 44) begin
            checks++;
            if (an !== 8'h7F || seg !== 7'h78) begin errors++; $display("FAIL basic_digit7 got %h/%h exp 7f/78", an, seg); end
         end
         if (c == 48) begin
            checks++;
            if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_fd48 got %b exp 1", frame_done); end
         end
         step();
      end
   endtask

   task automatic test_midframe_din();
      logic [7:0] ea; logic [6:0] es; logic ef;
      for (int i = 0; i < 96; i++) begin
         if (c % FRAME == 20) din = 32'hFFFFFFFF;
         model(ea, es, ef);
         checks += 3;
         if (an !== ea)         begin errors++; $display("FAIL mid_an c=%0d got %h exp %h", c, an, ea); end
         if (seg !== es)        begin errors++; $display("FAIL mid_seg c=%0d got %h exp %h", c, seg, es); end
         if (frame_done !== ef) begin errors++; $display("FAIL mid_fd c=%0d got %b exp %b", c, frame_done, ef); end
         if (c >= 2 * FRAME + G && (c % SLOT) >= G) begin
            checks++;
            if (seg !== 7'h0E) begin errors++; $display("FAIL mid_newframe c=%0d got %h exp 0e", c, seg); end
         end
         step();
      end
   endtask

   task automatic test_lz_blank();
      logic [7:0] ea; logic [6:0] es; logic ef;
      din = 32'h00000A05; lz_blank = 1'b1;
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         if (i == FRAME + 4) din = 32'd0;
         model(ea, es, ef);
         checks += 3;
         if (an !== ea)         begin errors++; $display("FAIL lz_an c=%0d got %h exp %h", c, an, ea); end
         if (seg !== es)        begin errors++; $display("FAIL lz_seg c=%0d got %h exp %h", c, seg, es); end
         if (frame_done !== ef) begin errors++; $display("FAIL lz_fd c=%0d got %b exp %b", c, frame_done, ef); end
         step();
      end
   endtask

   task automatic test_en_drop();
      logic [7:0] ea; logic [6:0] es; logic ef;
      int guard_cnt;
      din = 32'h89ABCDEF; lz_blank = 1'b0;
      guard_cnt = 0;
      while (c % FRAME != 5 * SLOT + 3 && guard_cnt < 2 * FRAME) begin
         step(); guard_cnt++;
      end
      checks++;
      if (c % FRAME != 5 * SLOT + 3) begin errors++; $display("FAIL en_reach got %0d exp %0d", c % FRAME, 5 * SLOT + 3); end
      en = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         model(ea, es, ef);
         checks += 3;
         if (an !== 8'hFF || an !== ea)  begin errors++; $display("FAIL en_off_an got %h exp ff", an); end
         if (seg !== 7'h7F || seg !== es) begin errors++; $display("FAIL en_off_seg got %h exp 7f", seg); end
         if (frame_done !== 1'b0)        begin errors++; $display("FAIL en_off_fd got %b exp 0", frame_done); end
      end
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         model(ea, es, ef);
         checks += 3;
         if (an !== ea)         begin errors++; $display("FAIL en_on_an c=%0d got %h exp %h", c, an, ea); end
         if (seg !== es)        begin errors++; $display("FAIL en_on_seg c=%0d got %h exp %h", c, seg, es); end
         if (frame_done !== ef) begin errors++; $display("FAIL en_on_fd c=%0d got %b exp %b", c, frame_done, ef); end
         if (i == 1 || i == 2) begin
            checks++;
            if (i == 1 && an !== 8'hFF) begin errors++; $display("FAIL en_guard got %h exp ff", an); end
            if (i == 2 && (an !== 8'hFE || seg !== 7'h0E)) begin errors++; $display("FAIL en_digit0 got %h/%h exp fe/0e", an, seg); end
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] ea; logic [6:0] es; logic ef;
      int guard_cnt;
      guard_cnt = 0;
      while (c % FRAME != 3 * SLOT + 3 && guard_cnt < 2 * FRAME) begin
         step(); guard_cnt++;
      end
      checks++;
      if (an !== 8'hF7) begin errors++; $display("FAIL arst_pre got %h exp f7", an); end
      rst = 1'b1;
      #1;
      checks += 3;
      if (an !== 8'hFF)        begin errors++; $display("FAIL arst_an got %h exp ff", an); end
      if (seg !== 7'h7F)       begin errors++; $display("FAIL arst_seg got %h exp 7f", seg); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL arst_fd got %b exp 0", frame_done); end
      step(); step();
      rst = 1'b0; din = 32'h13572468;
      for (int i = 0; i < FRAME + 6; i++) begin
         model(ea, es, ef);
         checks += 3;
         if (an !== ea)         begin errors++; $display("FAIL arst_an c=%0d got %h exp %h", c, an, ea); end
         if (seg !== es)        begin errors++; $display("FAIL arst_seg c=%0d got %h exp %h", c, seg, es); end
         if (frame_done !== ef) begin errors++; $display("FAIL arst_fd c=%0d got %b exp %b", c, frame_done, ef); end
         step();
      end
   endtask

   task automatic test_frame_period();
      int pulses;
      pulses = 0;
      exp_q.delete();
      for (int i = 0; i < 3 * FRAME + 4; i++) begin
         din = $urandom;
         checks++;
         if ($countones(~an) > 1) begin errors++; $display("FAIL period_onehot got %h exp <=1 low", an); end
         if (frame_done === 1'b1) begin
            pulses++;
            if (exp_q.size() > 0) begin
               logic [31:0] e;
               e = exp_q.pop_front();
               checks++;
               if (32'(t) !== e) begin errors++; $display("FAIL period_fd got %0d exp %0d", t, e); end
            end
            exp_q.push_back(32'(t + FRAME));
         end
         step();
      end
      checks++;
      if (pulses < 3) begin errors++; $display("FAIL period_count got %0d exp >=3", pulses); end
   endtask

   task automatic test_random();
      logic [7:0] ea; logic [6:0] es; logic ef;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0)  din = $urandom;
         if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(0, 3) == 0)  din = din & 32'h0000FFFF;
         if (en && $urandom_range(0, 149) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
         model(ea, es, ef);
         checks += 4;
         if (an !== ea)         begin errors++; $display("FAIL rnd_an c=%0d got %h exp %h", c, an, ea); end
         if (seg !== es)        begin errors++; $display("FAIL rnd_seg c=%0d got %h exp %h", c, seg, es); end
         if (frame_done !== ef) begin errors++; $display("FAIL rnd_fd c=%0d got %b exp %b", c, frame_done, ef); end
         if ($countones(~an) > 1) begin errors++; $display("FAIL rnd_onehot got %h exp <=1 low", an); end
         step();
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic_frame();
      test_midframe_din();
      test_lz_blank();
      test_en_drop();
      test_async_reset();
      test_frame_period();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
